rtmc_spi_regctl: RTL and testbench

SPI register-access controller that sequences the byte-level SPI shifter: parses the received byte stream into read/write commands and drives a simple single-cycle register bus. It also schedules transmit bytes back to the shifter: a sync byte during the command, then register read data. Sits between the SPI shifter and the design's register file, instantiated side by side with the shifter in the SPI top level.

---
 rtl/rtmc_spi_pkg.sv | 19 +
 rtl/rtmc_spi_regctl.sv | 141 ++++++++++++++
 tb/tb_rtmc_spi_regctl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtmc_spi_pkg.sv
// Shared definitions for the SPI register-access controller.
//   state_e           : controller FSM states
//   CMD_RD_BIT        : command-byte bit that selects read (1) or write (0)
//   REG_ADDR_W        : register address width
//   SYNC_BYTE_DEFAULT : default byte shifted out during the command byte
package rtmc_spi_pkg;

    localparam int         CMD_RD_BIT        = 7;
    localparam int         REG_ADDR_W        = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        CMD   = 2'd0,
        WR    = 2'd1,
        FETCH = 2'd2,
        RD    = 2'd3
    } state_e;

endpackage

// File: rtl/rtmc_spi_regctl.sv
// SPI register-access controller. It parses the byte stream from the SPI
// shifter into read/write commands, drives a single-cycle register bus, and
// offers transmit bytes back to the shifter: a sync byte during the command
// byte, then the register read data.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   cs_n                SPI chip select (high = frame idle)
//   din, din_valid      received byte from the shifter, one-cycle valid pulse
//   dout, dout_valid    byte offered to the shifter for the next transmit slot
//   dout_ack            one-cycle pulse: the shifter has started shifting dout
//   reg_addr/wdata/we   register write port (single-cycle strobe)
//   reg_re, reg_rdata   register read strobe, combinational read data
//   frame_active        high from the command byte until cs_n rises
//   dbg_state           current FSM state
//
// Handshake: dout is held stable while dout_valid is high. A dout_ack pulse
// in RD consumes the byte; dout_valid then drops until the next byte has been
// prefetched. dout_ack is ignored outside RD.
module rtmc_spi_regctl
    import rtmc_spi_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter bit         AUTO_INC  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic [7:0]            din,
    input  logic                  din_valid,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    input  logic                  dout_ack,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  frame_active,
    output state_e                dbg_state
);

    localparam logic [REG_ADDR_W-1:0] ADDR_STEP = {{(REG_ADDR_W-1){1'b0}}, AUTO_INC};

    state_e                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]              dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    frame_active_q, frame_active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CMD;
            addr_q         <= '0;
            dout_q         <= SYNC_BYTE;
            dout_valid_q   <= 1'b1;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            frame_active_q <= frame_active_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        dout_d         = dout_q;
        dout_valid_d   = dout_valid_q;
        wdata_d        = wdata_q;
        we_d           = 1'b0;
        frame_active_d = frame_active_q;

        if (cs_n) begin
            // Frame end wins over any byte event; the address is kept.
            state_d        = CMD;
            dout_d         = SYNC_BYTE;
            dout_valid_d   = 1'b1;
            frame_active_d = 1'b0;
        end else begin
            // The address advances after the write strobe cycle has used it.
            if (we_q) begin
                addr_d = addr_q + ADDR_STEP;
            end

            unique case (state_q)
                CMD: begin
                    dout_d       = SYNC_BYTE;
                    dout_valid_d = 1'b1;
                    if (din_valid) begin
                        addr_d         = din[REG_ADDR_W-1:0];
                        frame_active_d = 1'b1;
                        // Nothing to offer until the first read is prefetched;
                        // write frames shift zeros.
                        dout_valid_d   = 1'b0;
                        state_d        = din[CMD_RD_BIT] ? FETCH : WR;
                    end
                end
                WR: begin
                    if (din_valid) begin
                        we_d    = 1'b1;
                        wdata_d = din;
                    end
                end
                FETCH: begin
                    dout_d       = reg_rdata;
                    dout_valid_d = 1'b1;
                    state_d      = RD;
                end
                RD: begin
                    if (dout_ack) begin
                        dout_valid_d = 1'b0;
                        addr_d       = addr_q + ADDR_STEP;
                        state_d      = FETCH;
                    end
                end
                default: state_d = CMD;
            endcase
        end
    end

    // Strobes are gated by cs_n so that a frame ending in the strobe cycle
    // produces no register access.
    assign reg_we       = we_q & ~cs_n;
    assign reg_re       = (state_q == FETCH) & ~cs_n;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign frame_active = frame_active_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rtmc_spi_regctl.sv
module tb_rtmc_spi_regctl;
    import rtmc_spi_pkg::*;

    localparam int BYTE_CLK = 32;  // 8 bits at SCK = 4 clk

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       cs_n, din_valid, dout_ack;
    logic [7:0] din;

    logic [7:0] dout, reg_wdata, reg_rdata;
    logic       dout_valid, reg_we, reg_re, frame_active;
    logic [6:0] reg_addr;
    state_e     dbg_state;

    logic [7:0] dout_b, reg_wdata_b, reg_rdata_b;
    logic       dout_valid_b, reg_we_b, reg_re_b, frame_active_b;
    logic [6:0] reg_addr_b;
    state_e     dbg_state_b;

    logic [7:0] mem [0:127];
    assign reg_rdata   = mem[reg_addr];
    assign reg_rdata_b = mem[reg_addr_b];

    rtmc_spi_regctl u_dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ack(dout_ack),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .frame_active(frame_active), .dbg_state(dbg_state)
    );

    rtmc_spi_regctl #(.AUTO_INC(1'b0)) u_dut_noinc (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .din(din), .din_valid(din_valid),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_ack(dout_ack),
        .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b), .reg_we(reg_we_b), .reg_re(reg_re_b),
        .reg_rdata(reg_rdata_b), .frame_active(frame_active_b), .dbg_state(dbg_state_b)
    );

    // ---------------- observation ----------------
    logic [14:0] wr_obs[$];   // {addr, data}
    logic [6:0]  re_obs[$];
    logic [14:0] exp_q[$];
    logic        both_seen = 1'b0;

    always @(negedge clk) begin
        if (reg_we) begin
            wr_obs.push_back({reg_addr, reg_wdata});
            mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) re_obs.push_back(reg_addr);
        if (reg_we && reg_re) both_seen <= 1'b1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One byte slot of a simplified shifter: load dout (acking it) near the
    // start of the slot, deliver the received byte at the end of the slot.
    task automatic xfer(input logic [7:0] rx, output logic [7:0] tx, output logic [7:0] tx_b);
        tx   = dout_valid   ? dout   : 8'h00;
        tx_b = dout_valid_b ? dout_b : 8'h00;
        dout_ack = dout_valid;
        tick;
        dout_ack = 1'b0;
        repeat (BYTE_CLK - 3) tick;
        din       = rx;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        tick;
    endtask

    task automatic frame_start;
        wr_obs.delete();
        re_obs.delete();
        cs_n = 1'b0;
        tick;
    endtask

    task automatic frame_end;
        cs_n = 1'b1;
        tick;
        tick;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, wr_obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_obs.size()) check({tag, "_entry"}, {17'd0, wr_obs[i]}, {17'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(CMD));
        check({tag, "_dout"}, dout, 8'hA5);
        check({tag, "_dout_valid"}, dout_valid, 1);
        check({tag, "_frame_active"}, frame_active, 0);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] tx, tx_b;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rst_n = 1'b0; cs_n = 1'b1; din = 8'h00; din_valid = 1'b0; dout_ack = 1'b0;
        repeat (3) tick;

        // Reset values
        check_idle("reset");
        check("reset_addr", reg_addr, 0);
        check("reset_wdata", reg_wdata, 0);
        check("reset_we", reg_we, 0);
        check("reset_re", reg_re, 0);
        rst_n = 1'b1;
        tick; tick;

        // Write burst 0x10: 0x11, 0x22, 0x33
        frame_start;
        xfer(8'h10, tx, tx_b); check("wr_sdo0", tx, 8'hA5);
        check("wr_frame_active", frame_active, 1);
        xfer(8'h11, tx, tx_b); check("wr_sdo1", tx, 8'h00);
        xfer(8'h22, tx, tx_b); check("wr_sdo2", tx, 8'h00);
        xfer(8'h33, tx, tx_b); check("wr_sdo3", tx, 8'h00);
        frame_end;
        exp_q.push_back({7'h10, 8'h11});
        exp_q.push_back({7'h11, 8'h22});
        exp_q.push_back({7'h12, 8'h33});
        check_writes("wr_burst");
        check("wr_no_re", re_obs.size(), 0);
        check_idle("wr_end");

        // Read burst 0xA0 with prefetch of 0x23
        mem[8'h20] = 8'hDE; mem[8'h21] = 8'hAD; mem[8'h22] = 8'hBE; mem[8'h23] = 8'h77;
        frame_start;
        xfer(8'hA0, tx, tx_b); check("rd_sdo0", tx, 8'hA5);
        xfer(8'hFF, tx, tx_b); check("rd_sdo1", tx, 8'hDE);
        xfer(8'hFF, tx, tx_b); check("rd_sdo2", tx, 8'hAD);
        xfer(8'hFF, tx, tx_b); check("rd_sdo3", tx, 8'hBE);
        frame_end;
        check("rd_re_count", re_obs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < re_obs.size()) check("rd_re_addr", re_obs[i], 7'h20 + 7'(i));
        end
        check("rd_no_we", wr_obs.size(), 0);
        check_idle("rd_end");

        // Address wrap 0x7F -> 0x00
        frame_start;
        xfer(8'h7F, tx, tx_b);
        xfer(8'hC1, tx, tx_b);
        xfer(8'hC2, tx, tx_b);
        frame_end;
        exp_q.push_back({7'h7F, 8'hC1});
        exp_q.push_back({7'h00, 8'hC2});
        check_writes("wrap");

        // Fixed address (second instance) vs incrementing (first instance)
        mem[5] = 8'h5A; mem[6] = 8'h6B; mem[7] = 8'h7C;
        frame_start;
        xfer(8'h85, tx, tx_b); check("inc_sdo0", tx, 8'hA5); check("noinc_sdo0", tx_b, 8'hA5);
        xfer(8'h00, tx, tx_b); check("inc_sdo1", tx, 8'h5A); check("noinc_sdo1", tx_b, 8'h5A);
        xfer(8'h00, tx, tx_b); check("inc_sdo2", tx, 8'h6B); check("noinc_sdo2", tx_b, 8'h5A);
        xfer(8'h00, tx, tx_b); check("inc_sdo3", tx, 8'h7C); check("noinc_sdo3", tx_b, 8'h5A);
        frame_end;
        check("noinc_addr", reg_addr_b, 7'h05);

        // Abort mid-byte during a write: one strobe only
        frame_start;
        xfer(8'h40, tx, tx_b);
        din = 8'h99; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        check("wr_latency_we", reg_we, 1);
        check("wr_latency_addr", reg_addr, 7'h40);
        check("wr_latency_data", reg_wdata, 8'h99);
        repeat (BYTE_CLK + 16) tick;
        frame_end;
        exp_q.push_back({7'h40, 8'h99});
        check_writes("abort");
        check_idle("abort_end");
        frame_start;
        xfer(8'h50, tx, tx_b); check("abort_next_sdo0", tx, 8'hA5);
        frame_end;

        // Abort in the FETCH cycle
        frame_start;
        repeat (BYTE_CLK - 2) tick;
        din = 8'hA0; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        check("fetch_state", 32'(dbg_state), 32'(FETCH));
        cs_n = 1'b1;
        #1;
        check("fetch_abort_re", reg_re, 0);
        tick;
        check_idle("fetch_abort");
        check("fetch_abort_re_count", re_obs.size(), 0);
        tick;

        // Reset mid-read
        frame_start;
        xfer(8'hA0, tx, tx_b);
        xfer(8'hFF, tx, tx_b); check("mid_rd_sdo1", tx, 8'hDE);
        check("mid_rd_dout", dout, 8'hAD);
        check("mid_rd_valid", dout_valid, 1);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_addr", reg_addr, 0);
        check("mid_reset_wdata", reg_wdata, 0);
        check("mid_reset_we", reg_we, 0);
        check("mid_reset_re", reg_re, 0);
        cs_n = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;

        check("never_we_and_re", both_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
